// File: rtl/seq_and_mult.sv
// Iterative unsigned shift-and-add multiplier: ROWS AND-gated partial-product rows are
// folded into a 2*WIDTH accumulator per cycle, giving a fixed WIDTH/ROWS-cycle run.
module seq_and_mult #(
   parameter int WIDTH = 32,
   parameter int ROWS  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [2*WIDTH-1:0]   PRODUCT
);

   localparam int N    = WIDTH / ROWS;
   localparam int CNTW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t              state, state_nxt;
   logic [2*WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]    mplier;
   logic [2*WIDTH-1:0]  acc;
   logic [2*WIDTH-1:0]  psum;
   logic [CNTW-1:0]     count;
   logic                accept;
   logic                last;

   assign accept = START && (state == IDLE || state == FIN);
   assign last   = (state == RUN) && (count == CNTW'(1));
   assign BUSY   = (state == RUN);
   assign DONE   = (state == FIN);

   // mcand is pre-shifted by i*ROWS, so only the row offset k is applied here
   always_comb begin
      psum = '0;
      for (int k = 0; k < ROWS; k++) begin
         if (mplier[k]) psum = psum + (mcand << k);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last)   state_nxt = FIN;
         FIN:     state_nxt = START ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         PRODUCT <= '0;
      end else if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         acc    <= '0;
         count  <= CNTW'(N);
      end else if (state == RUN) begin
         acc    <= acc + psum;
         mcand  <= mcand << ROWS;
         mplier <= mplier >> ROWS;
         count  <= count - CNTW'(1);
         if (last) PRODUCT <= acc + psum;
      end
   end

endmodule

// File: tb/tb_seq_and_mult.sv
// Bench for seq_and_mult: directed scenarios plus randomized operands across several
// WIDTH/ROWS configurations, checked against a plain A*B reference.
module tb_seq_and_mult;

   localparam int NI = 6;

   function automatic int wof(int g);
      case (g)
         0: return 32;  1: return 32;  2: return 16;
         3: return 8;   4: return 32;  default: return 8;
      endcase
   endfunction

   function automatic int rof(int g);
      case (g)
         0: return 1;   1: return 4;   2: return 4;
         3: return 8;   4: return 2;   default: return 1;
      endcase
   endfunction

   logic        clk, rst;
   logic        start [NI];
   logic        busy  [NI];
   logic        done  [NI];
   logic [63:0] prod  [NI];
   logic [31:0] a, b;

   int pass_cnt = 0;
   int total    = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = wof(g);
      localparam int R = rof(g);
      logic [2*W-1:0] p;
      seq_and_mult #(.WIDTH(W), .ROWS(R)) u_dut (
         .CLK(clk), .RST(rst), .START(start[g]),
         .A(a[W-1:0]), .B(b[W-1:0]),
         .BUSY(busy[g]), .DONE(done[g]), .PRODUCT(p)
      );
      assign prod[g] = 64'(p);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(int w, logic [31:0] x, logic [31:0] y);
      logic [63:0] m, xx, yy;
      m  = (64'd1 << w) - 64'd1;
      xx = {32'd0, x} & m;
      yy = {32'd0, y} & m;
      return xx * yy;
   endfunction

   // One operation on instance idx; reports result, latency, busy cycles and post-DONE level.
   task automatic do_op(input int idx, input logic [31:0] ai, input logic [31:0] bi,
                        output logic [63:0] p, output int lat, output int bcnt,
                        output logic dpost);
      int n;
      n = wof(idx) / rof(idx);
      @(negedge clk);
      a = ai; b = bi; start[idx] = 1'b1;
      @(negedge clk);
      start[idx] = 1'b0; a = 'x; b = 'x;
      lat = 0; bcnt = 0;
      while (!done[idx] && lat < n + 8) begin
         if (busy[idx]) bcnt++;
         @(negedge clk);
         lat++;
      end
      p = prod[idx];
      @(negedge clk);
      dpost = done[idx];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a = '0; b = '0;
      for (int i = 0; i < NI; i++) start[i] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         total++;
         if (busy[i] !== 1'b0 || done[i] !== 1'b0 || prod[i] !== 64'd0)
            $display("FAIL reset[%0d] busy=%b done=%b product=%h, want 0/0/0", i, busy[i], done[i], prod[i]);
         else pass_cnt++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [63:0] p; int lat, bcnt; logic dpost;
      do_op(0, 32'd3, 32'd5, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'd15) $display("FAIL t1_product got %h want %h", p, 64'd15);
      else pass_cnt++;
      total++;
      if (lat !== 32 || bcnt !== 32) $display("FAIL t1_timing lat=%0d busy=%0d want 32/32", lat, bcnt);
      else pass_cnt++;
      total++;
      if (dpost !== 1'b0) $display("FAIL t1_done_pulse done after=%b want 0", dpost);
      else pass_cnt++;
   endtask

   task automatic test_extremes();
      logic [63:0] p; int lat, bcnt; logic dpost;
      do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL t2_max got %h want %h", p, 64'hFFFF_FFFE_0000_0001);
      else pass_cnt++;
      do_op(0, 32'h8000_0000, 32'd2, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'h1_0000_0000) $display("FAIL t2_msb got %h want %h", p, 64'h1_0000_0000);
      else pass_cnt++;
      do_op(1, 32'h1234_5678, 32'h9ABC_DEF0, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'h0B00_EA4E_242D_2080) $display("FAIL t3_rows4 got %h want %h", p, 64'h0B00_EA4E_242D_2080);
      else pass_cnt++;
      total++;
      if (lat !== 8 || bcnt !== 8) $display("FAIL t3_timing lat=%0d busy=%0d want 8/8", lat, bcnt);
      else pass_cnt++;
   endtask

   task automatic test_zero();
      logic [63:0] p; int lat, bcnt; logic dpost;
      do_op(0, 32'd0, $urandom, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'd0 || lat !== 32) $display("FAIL zero_a got %h lat=%0d want 0 lat=32", p, lat);
      else pass_cnt++;
      do_op(4, $urandom, 32'd0, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'd0 || lat !== 16) $display("FAIL zero_b got %h lat=%0d want 0 lat=16", p, lat);
      else pass_cnt++;
   endtask

   task automatic test_start_in_run();
      int dcnt; logic [63:0] p;
      @(negedge clk);
      a = 32'd6; b = 32'd9; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      dcnt = 0; p = '0;
      for (int c = 0; c < 40; c++) begin
         if (done[0]) begin dcnt++; p = prod[0]; end
         if (c == 5) begin start[0] = 1'b1; a = 32'd7; b = 32'd7; end
         else start[0] = 1'b0;
         @(negedge clk);
      end
      total++;
      if (dcnt !== 1 || p !== 64'd54) $display("FAIL t4_ignore dones=%0d product=%0d want 1/54", dcnt, p);
      else pass_cnt++;
      total++;
      if (busy[0] !== 1'b0 || prod[0] !== 64'd54) $display("FAIL t4_after busy=%b product=%0d want 0/54", busy[0], prod[0]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int d1, d2; logic [63:0] p1, p2, mid;
      @(negedge clk);
      a = 32'd2; b = 32'd3; start[0] = 1'b1;
      @(negedge clk);
      a = 32'd4; b = 32'd5;
      d1 = -1; d2 = -1; p1 = '0; p2 = '0; mid = '0;
      for (int c = 0; c < 80 && d2 < 0; c++) begin
         if (done[0]) begin
            if (d1 < 0) begin d1 = c; p1 = prod[0]; end
            else begin d2 = c; p2 = prod[0]; start[0] = 1'b0; end
         end
         if (c == 33 + 10) mid = prod[0];
         @(negedge clk);
      end
      start[0] = 1'b0;
      total++;
      if (d1 !== 32 || d2 - d1 !== 33) $display("FAIL t5_spacing first=%0d gap=%0d want 32/33", d1, d2 - d1);
      else pass_cnt++;
      total++;
      if (p1 !== 64'd6 || mid !== 64'd6 || p2 !== 64'd20)
         $display("FAIL t5_products got %0d/%0d/%0d want 6/6/20", p1, mid, p2);
      else pass_cnt++;
      total++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) $display("FAIL t5_idle done=%b busy=%b want 0/0", done[0], busy[0]);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] p; int lat, bcnt; logic dpost;
      @(negedge clk);
      a = 32'hDEAD; b = 32'hBEEF; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || prod[0] !== 64'd0)
         $display("FAIL t6_abort busy=%b done=%b product=%h want 0/0/0", busy[0], done[0], prod[0]);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      do_op(0, 32'd10, 32'd10, p, lat, bcnt, dpost);
      total++;
      if (p !== 64'd100 || lat !== 32) $display("FAIL t6_recover got %0d lat=%0d want 100 lat=32", p, lat);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [63:0] p, exp; int lat, bcnt, n; logic dpost;
      logic [31:0] x, y;
      for (int g = 0; g < NI; g++) begin
         n = wof(g) / rof(g);
         for (int it = 0; it < 150; it++) begin
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
               0: x = '1;
               1: y = '1;
               2: x = 32'd1 << $urandom_range(0, 31);
               default: ;
            endcase
            exp = ref_mul(wof(g), x, y);
            do_op(g, x, y, p, lat, bcnt, dpost);
            total++;
            if (p !== exp || lat !== n || bcnt !== n)
               $display("FAIL rand[w%0d r%0d] a=%h b=%h got %h lat=%0d busy=%0d want %h lat=%0d",
                        wof(g), rof(g), x, y, p, lat, bcnt, exp, n);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_zero();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
